// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, debug and ROM signals around imem_port_arbiter.
// The master modport is the system side: requesters plus the ROM data return.
interface imem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_rerr;

  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_rerr;

  logic [31:0] mem_addr;
  logic [31:0] mem_inst;

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, mem_inst,
    input  if_gnt, if_rvalid, if_rdata, if_rerr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr, mem_addr
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, mem_inst,
    output if_gnt, if_rvalid, if_rdata, if_rerr,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr, mem_addr
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Fetch/debug arbiter in front of the 256-word combinational instruction ROM.
// Define IMEM_ARB_STARVE_GUARD_EN to force a debug grant after STARVE_LIMIT denials.

// One response register set per port; the fault mask keeps ROM data off faulty reads.
module imem_arb_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic        fault,
  input  logic [31:0] inst,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
      rerr   <= 1'b0;
    end else begin
      rvalid <= gnt;
      if (gnt) begin
        rdata <= fault ? 32'h0 : inst;
        rerr  <= fault;
      end
    end
  end
endmodule

module imem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  imem_port_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;
  localparam int P_IF  = 0;
  localparam int P_DBG = 1;

  logic [NUM_PORTS-1:0]       req, gnt, fault, rvalid, rerr;
  logic [NUM_PORTS-1:0][31:0] addr, rdata;
  logic                       force_dbg;

  assign req  = {bus.dbg_req, bus.if_req};
  assign addr = {bus.dbg_addr, bus.if_addr};

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign force_dbg = (int'(starve_cnt) >= STARVE_LIMIT);

  // Counts cycles debug is left waiting; any grant or withdrawal restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= 8'h0;
    else if (req[P_DBG] && !gnt[P_DBG])
      starve_cnt <= (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'h1;
    else
      starve_cnt <= 8'h0;
  end
`else
  // Without the guard the limit has no effect.
  logic [31:0] unused_limit;
  assign unused_limit = 32'(STARVE_LIMIT);
  assign force_dbg    = 1'b0;
`endif

  always_comb begin
    gnt = '0;
    if (req[P_IF] && !(req[P_DBG] && force_dbg))
      gnt[P_IF] = 1'b1;
    else if (req[P_DBG])
      gnt[P_DBG] = 1'b1;
  end

  always_comb begin
    bus.mem_addr = 32'h0;
    if (gnt[P_IF])
      bus.mem_addr = addr[P_IF];
    else if (gnt[P_DBG])
      bus.mem_addr = addr[P_DBG];
  end

  // Misaligned or beyond-ROM addresses fault instead of aliasing into the array.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    assign fault[p] = (|addr[p][1:0]) || (|addr[p][31:10]);

    imem_arb_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .gnt    (gnt[p]),
      .fault  (fault[p]),
      .inst   (bus.mem_inst),
      .rvalid (rvalid[p]),
      .rdata  (rdata[p]),
      .rerr   (rerr[p])
    );
  end

  assign bus.if_gnt     = gnt[P_IF];
  assign bus.if_rvalid  = rvalid[P_IF];
  assign bus.if_rdata   = rdata[P_IF];
  assign bus.if_rerr    = rerr[P_IF];
  assign bus.dbg_gnt    = gnt[P_DBG];
  assign bus.dbg_rvalid = rvalid[P_DBG];
  assign bus.dbg_rdata  = rdata[P_DBG];
  assign bus.dbg_rerr   = rerr[P_DBG];
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: grant model plus per-port response scoreboard.
// Build with IMEM_ARB_STARVE_GUARD_EN to exercise the starvation guard expectations.
module tb_imem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_port_arbiter_if bus();

  imem_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ROM holds 19 programmed words; the rest read as zero.
  function automatic logic [31:0] rom_word(input logic [7:0] i);
    return (i < 8'd19) ? {8'hC0, i, ~i, i} : 32'h0;
  endfunction

  assign bus.mem_inst = rom_word(bus.mem_addr[9:2]);

  function automatic logic [32:0] exp_resp(input logic [31:0] a);
    if ((a[1:0] != 2'b0) || (a[31:10] != 22'b0)) return {1'b1, 32'h0};
    return {1'b0, rom_word(a[9:2])};
  endfunction

  int          nchk = 0;
  int          npass = 0;
  int          scnt = 0;
  int          dbg_seen = 0;
  logic [32:0] q_if[$];
  logic [32:0] q_dbg[$];
  logic [32:0] held_if = '0;
  logic [32:0] held_dbg = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_resp();
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(q_if.size() != 0));
    if (q_if.size() != 0) held_if = q_if.pop_front();
    chk("if_rdata", bus.if_rdata, held_if[31:0]);
    chk("if_rerr", 32'(bus.if_rerr), 32'(held_if[32]));
    chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(q_dbg.size() != 0));
    if (q_dbg.size() != 0) held_dbg = q_dbg.pop_front();
    chk("dbg_rdata", bus.dbg_rdata, held_dbg[31:0]);
    chk("dbg_rerr", 32'(bus.dbg_rerr), 32'(held_dbg[32]));
  endtask

  // One arbitration cycle: drive, check grant, score the expected response, check it after the edge.
  task automatic step(input logic iq, input logic [31:0] ia, input logic dq, input logic [31:0] da);
    logic frc, eg_if, eg_dbg;
    bus.if_req = iq; bus.if_addr = ia;
    bus.dbg_req = dq; bus.dbg_addr = da;
    #1;
    frc = 1'b0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
    frc = (scnt >= 8);
`endif
    eg_dbg = dq && (!iq || frc);
    eg_if  = iq && !eg_dbg;
    chk("if_gnt", 32'(bus.if_gnt), 32'(eg_if));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(eg_dbg));
    chk("mem_addr", bus.mem_addr, eg_if ? ia : (eg_dbg ? da : 32'h0));
    if (bus.dbg_gnt === 1'b1) dbg_seen++;
    if (!reset) begin
      if (eg_if)  q_if.push_back(exp_resp(ia));
      if (eg_dbg) q_dbg.push_back(exp_resp(da));
      scnt = (dq && !eg_dbg) ? ((scnt < 255) ? scnt + 1 : 255) : 0;
    end
    @(posedge clk);
    #1;
    check_resp();
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0;
    reset = 1'b1;
    #1;
    check_resp();
    // Grant follows inputs under reset, but no response may appear.
    step(1'b1, 32'h8, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 32'h8, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) step(1'b1, 32'(i * 4), 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0);

    step(1'b0, 32'h0, 1'b1, 32'h6);
    step(1'b0, 32'h0, 1'b1, 32'h400);
    step(1'b0, 32'h0, 1'b1, 32'h44);
    step(1'b1, 32'h2, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h8000_0000);
    step(1'b1, 32'h3FC, 1'b1, 32'h3FC);
    step(1'b0, 32'h0, 1'b0, 32'h0);

    dbg_seen = 0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 20; i++) step(1'b1, 32'((i % 16) * 4), 1'b1, 32'hC);
    chk("dbg_grants_contended", 32'(dbg_seen), 32'd2);
`else
    for (int i = 0; i < 100; i++) step(1'b1, 32'((i % 16) * 4), 1'b1, 32'hC);
    chk("dbg_grants_contended", 32'(dbg_seen), 32'd0);
`endif
    step(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset mid-burst must clear responses without waiting for a clock.
    step(1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0);
    chk("pre_reset_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    #1 reset = 1'b1;
    #1;
    q_if.delete(); q_dbg.delete();
    held_if = '0; held_dbg = '0; scnt = 0;
    check_resp();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b1, 32'h10);
    step(1'b0, 32'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
